// File: rtl/tdm_demux_pkg.sv
// Shared types for the TDM receive path: FSM state encoding.
// Encodings match the mux-tree sender so both ends read the same in waveforms.
// No logic here; types only.
package tdm_demux_pkg;

  // Receiver frame state: waiting for slot 0, or collecting slots 1..NCH-1
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } state_t;

endpackage

// File: rtl/demux_decode.sv
// Purpose: slot index -> one-hot shadow-register write enable (inverse of the sender's select tree).
// Latency: combinational, zero cycles.
// Backpressure: none; all enables forced low when en is low.
module demux_decode #(
  parameter int NCH  = 4,
  parameter int SELW = 2
) (
  input  logic [SELW-1:0] sel,
  input  logic            en,
  output logic [NCH-1:0]  we
);

  // One-hot decode of the selected slot, gated by the enable
  always_comb begin
    we = '0;
    for (int k = 0; k < NCH; k++) begin
      if (en && (sel == SELW'(k))) we[k] = 1'b1;
    end
  end

endmodule

// File: rtl/tdm_demux.sv
// Purpose: rebuild an NCH-bit parallel word from a 1-bit TDM link, one bit per valid slot.
// Latency: ch_out/frame_valid registered, visible one cycle after the last slot is sampled.
// Backpressure: none; the link cannot be stalled, gaps (din_valid=0) just hold position.
module tdm_demux
  import tdm_demux_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int SELW = 2
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            din,
  input  logic            din_valid,
  input  logic            frame_start,
  output logic [NCH-1:0]  ch_out,
  output logic            frame_valid,
  output logic [SELW-1:0] sel_out,
  output logic            sync_err
);

  // A single-channel frame has no slot structure; refuse to build it.
  if (NCH < 2) begin : g_bad_nch
    $error("tdm_demux: NCH must be >= 2");
  end
  if (SELW < $clog2(NCH)) begin : g_bad_selw
    $error("tdm_demux: SELW too narrow for NCH");
  end

  state_t          state;
  logic [SELW-1:0] slot;
  logic [NCH-2:0]  shadow;
  logic [NCH-1:0]  we;
  logic            accept;
  logic [SELW-1:0] wr_sel;

  // A bit is kept when it opens a frame or continues one; stray bits in IDLE are dropped.
  // frame_start always targets slot 0, which also covers the resync case.
  assign accept = din_valid & (frame_start | (state == ST_RECV));
  assign wr_sel = frame_start ? '0 : slot;

  demux_decode #(
    .NCH  (NCH),
    .SELW (SELW)
  ) u_decode (
    .sel (wr_sel),
    .en  (accept),
    .we  (we)
  );

  // Shadow capture for slots 0..NCH-2; the last slot goes straight to ch_out.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      shadow <= '0;
    end else begin
      for (int k = 0; k < NCH - 1; k++) begin
        if (we[k]) shadow[k] <= din;
      end
    end
  end

  // Frame FSM with slot counter and registered outputs; we[NCH-1] marks the completing bit.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      slot        <= '0;
      ch_out      <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      if (din_valid) begin
        case (state)
          ST_IDLE: begin
            if (frame_start) begin
              slot  <= SELW'(1);
              state <= ST_RECV;
            end
          end
          ST_RECV: begin
            if (frame_start) begin
              sync_err <= 1'b1;
              slot     <= SELW'(1);
            end else if (we[NCH-1]) begin
              ch_out      <= {din, shadow};
              frame_valid <= 1'b1;
              slot        <= '0;
              state       <= ST_IDLE;
            end else begin
              slot <= slot + SELW'(1);
            end
          end
          default: begin
            state <= ST_IDLE;
            slot  <= '0;
          end
        endcase
      end
    end
  end

  assign sel_out = slot;

endmodule

// File: tb/tb_tdm_demux.sv
// Bench for tdm_demux: directed frames, gaps, resync, stray data and async reset,
// then randomized link traffic, all compared against a queue-based frame model.
// One cycle per step: drive after the edge, sample outputs 1ns after the next edge.
`timescale 1ns/1ps
module tb_tdm_demux;

  localparam int NCH  = 4;
  localparam int SELW = 2;

  logic            clock;
  logic            resetn;
  logic            din;
  logic            din_valid;
  logic            frame_start;
  logic [NCH-1:0]  ch_out;
  logic            frame_valid;
  logic [SELW-1:0] sel_out;
  logic            sync_err;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: bits collected for the frame in progress, last published word
  bit             frm_q[$];
  logic [NCH-1:0] m_ch;
  logic           m_fv;
  logic           m_se;
  int             n_fv;
  int             n_se;

  tdm_demux #(.NCH(NCH), .SELW(SELW)) dut (
    .clock       (clock),
    .resetn      (resetn),
    .din         (din),
    .din_valid   (din_valid),
    .frame_start (frame_start),
    .ch_out      (ch_out),
    .frame_valid (frame_valid),
    .sel_out     (sel_out),
    .sync_err    (sync_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".ch_out"},      32'(ch_out),      32'(m_ch));
    chk({tag, ".frame_valid"}, 32'(frame_valid), 32'(m_fv));
    chk({tag, ".sync_err"},    32'(sync_err),    32'(m_se));
    chk({tag, ".sel_out"},     32'(sel_out),     32'(frm_q.size()));
  endtask

  // Model the effect of one sampled link cycle
  task automatic model_step(input logic d, input logic v, input logic fs);
    m_fv = 1'b0;
    m_se = 1'b0;
    if (v) begin
      if (fs) begin
        if (frm_q.size() != 0) m_se = 1'b1;
        frm_q.delete();
        frm_q.push_back(d);
      end else if (frm_q.size() != 0) begin
        frm_q.push_back(d);
        if (frm_q.size() == NCH) begin
          for (int k = 0; k < NCH; k++) m_ch[k] = frm_q[k];
          m_fv = 1'b1;
          frm_q.delete();
        end
      end
    end
  endtask

  task automatic step(input logic d, input logic v, input logic fs, input string tag);
    din         = d;
    din_valid   = v;
    frame_start = fs;
    @(posedge clock);
    #1;
    model_step(d, v, fs);
    if (m_fv) n_fv++;
    if (m_se) n_se++;
    chk_all(tag);
  endtask

  // Word bit k goes out in slot k, frame_start on slot 0
  task automatic send_word(input logic [NCH-1:0] w, input string tag);
    for (int k = 0; k < NCH; k++) step(w[k], 1'b1, (k == 0), tag);
  endtask

  // Asynchronous reset asserted between edges, checked before any clock edge
  task automatic do_reset(input string tag);
    din_valid   = 1'b0;
    frame_start = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    frm_q.delete();
    m_ch = '0;
    m_fv = 1'b0;
    m_se = 1'b0;
    chk_all({tag, ".async"});
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock);
    #1;
    chk_all({tag, ".post"});
  endtask

  initial begin
    logic [NCH-1:0] w;
    int fv_before;
    resetn      = 1'b0;
    din         = 1'b0;
    din_valid   = 1'b0;
    frame_start = 1'b0;
    frm_q.delete();
    m_ch = '0;
    m_fv = 1'b0;
    m_se = 1'b0;
    n_fv = 0;
    n_se = 0;
    repeat (2) @(posedge clock);
    #1;
    chk_all("rst");
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock);
    #1;

    // Basic frame 1,0,1,1 -> 4'b1101
    w = 4'b1101;
    send_word(w, "basic");
    chk("basic.value", 32'(ch_out), 32'h0000000d);
    chk("basic.pulse", 32'(frame_valid), 32'h1);
    step(1'b0, 1'b0, 1'b0, "basic.after");
    chk("basic.pulse_gone", 32'(frame_valid), 32'h0);

    // Reset mid-frame at slot 2, then stray bits must not capture
    step(1'b1, 1'b1, 1'b1, "rstmid");
    step(1'b1, 1'b1, 1'b0, "rstmid");
    chk("rstmid.sel2", 32'(sel_out), 32'h2);
    do_reset("rstmid");
    for (int i = 0; i < NCH; i++) step(1'b1, 1'b1, 1'b0, "rstmid.stray");
    chk("rstmid.nocap", 32'(ch_out), 32'h0);

    // Gaps of 3 cycles between slots 1 and 2
    step(1'b1, 1'b1, 1'b1, "gap");
    step(1'b0, 1'b1, 1'b0, "gap");
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, "gap.hold");
      chk("gap.sel_hold", 32'(sel_out), 32'h2);
    end
    step(1'b1, 1'b1, 1'b0, "gap");
    step(1'b1, 1'b1, 1'b0, "gap");
    chk("gap.value", 32'(ch_out), 32'h0000000d);

    // Resync: 1,1 then restart with 0,0,1,0 -> 4'b0100
    step(1'b1, 1'b1, 1'b1, "resync");
    step(1'b1, 1'b1, 1'b0, "resync");
    step(1'b0, 1'b1, 1'b1, "resync.fs");
    chk("resync.err", 32'(sync_err), 32'h1);
    chk("resync.held", 32'(ch_out), 32'h0000000d);
    step(1'b0, 1'b1, 1'b0, "resync");
    step(1'b1, 1'b1, 1'b0, "resync");
    step(1'b0, 1'b1, 1'b0, "resync");
    chk("resync.value", 32'(ch_out), 32'h00000004);

    // Back-to-back frames, no idle cycle between
    fv_before = n_fv;
    send_word(4'b1010, "b2b.a");
    chk("b2b.a", 32'(ch_out), 32'h0000000a);
    send_word(4'b0101, "b2b.b");
    chk("b2b.b", 32'(ch_out), 32'h00000005);
    chk("b2b.count", 32'(n_fv - fv_before), 32'h2);

    // Stray data from IDLE
    for (int i = 0; i < 5; i++) begin
      step(i[0], 1'b1, 1'b0, "stray");
      chk("stray.sel", 32'(sel_out), 32'h0);
    end

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic d, v, fs;
      d  = 1'($urandom);
      v  = ($urandom_range(0, 3) != 0);
      fs = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 399) == 0) do_reset("rand.rst");
      else step(d, v, fs, "rand");
    end
    chk("rand.saw_frames", 32'(n_fv > 20), 32'h1);
    chk("rand.saw_resync", 32'(n_se > 5), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
